// File: rtl/divider_requester.sv
// divider_requester: initiator side of the iterative-divider channel interface.
// Accepts one (lhs, rhs) command, offers the operands on two independent
// valid/ready channels, collects the quotient (or times out) and returns
// {result, timeout, div_zero} on the response channel. One command in flight.
// Late results arriving while idle are consumed and counted in stale_cnt.
//
// Ports:
//   clk, rst                          clock, async active-low reset
//   cmd_lhs/cmd_rhs/cmd_vld/cmd_rdy   command channel
//   divider__lhs[_vld/_rdy]           dividend channel to divider
//   divider__rhs[_vld/_rdy]           divisor channel to divider
//   divider__result[_vld/_rdy]        quotient channel from divider
//   rsp_result/rsp_timeout/rsp_div_zero/rsp_vld/rsp_rdy  response channel
//   stale_cnt                         saturating count of dropped late results
module divider_requester #(
  parameter int unsigned W       = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] cmd_lhs,
  input  logic [W-1:0] cmd_rhs,
  input  logic         cmd_vld,
  output logic         cmd_rdy,
  output logic [W-1:0] divider__lhs,
  output logic         divider__lhs_vld,
  input  logic         divider__lhs_rdy,
  output logic [W-1:0] divider__rhs,
  output logic         divider__rhs_vld,
  input  logic         divider__rhs_rdy,
  input  logic [W-1:0] divider__result,
  input  logic         divider__result_vld,
  output logic         divider__result_rdy,
  output logic [W-1:0] rsp_result,
  output logic         rsp_timeout,
  output logic         rsp_div_zero,
  output logic         rsp_vld,
  input  logic         rsp_rdy,
  output logic [7:0]   stale_cnt
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RES, RESP} state_e;

  state_e         state_q, state_d;
  logic           cmd_rdy_q, cmd_rdy_d;
  logic [W-1:0]   lhs_q, lhs_d;
  logic           lhs_vld_q, lhs_vld_d;
  logic [W-1:0]   rhs_q, rhs_d;
  logic           rhs_vld_q, rhs_vld_d;
  logic           res_rdy_q, res_rdy_d;
  logic [W-1:0]   rsp_result_q, rsp_result_d;
  logic           rsp_timeout_q, rsp_timeout_d;
  logic           rsp_div_zero_q, rsp_div_zero_d;
  logic           rsp_vld_q, rsp_vld_d;
  logic [CW-1:0]  stale_q, stale_d;
  logic [TW-1:0]  timer_q, timer_d;

  // Handshake qualifiers shared by both combinational processes
  logic cmd_fire, lhs_pend, rhs_pend, res_fire, timer_exp, rsp_fire;
  assign cmd_fire  = cmd_vld & cmd_rdy_q;
  assign lhs_pend  = lhs_vld_q & ~divider__lhs_rdy;
  assign rhs_pend  = rhs_vld_q & ~divider__rhs_rdy;
  assign res_fire  = divider__result_vld & res_rdy_q;
  assign timer_exp = (timer_q == TW'(TIMEOUT - 1));
  assign rsp_fire  = rsp_vld_q & rsp_rdy;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (cmd_fire) state_d = SEND;
      SEND:     if (!lhs_pend && !rhs_pend) state_d = WAIT_RES;
      WAIT_RES: if (res_fire || timer_exp) state_d = RESP;
      RESP:     if (rsp_fire) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Output and datapath next values; handshake flags follow the next state
  always_comb begin
    cmd_rdy_d      = (state_d == IDLE);
    res_rdy_d      = (state_d == IDLE) || (state_d == WAIT_RES);
    rsp_vld_d      = (state_d == RESP);
    lhs_d          = lhs_q;
    lhs_vld_d      = lhs_vld_q;
    rhs_d          = rhs_q;
    rhs_vld_d      = rhs_vld_q;
    rsp_result_d   = rsp_result_q;
    rsp_timeout_d  = rsp_timeout_q;
    rsp_div_zero_d = rsp_div_zero_q;
    stale_d        = stale_q;
    timer_d        = timer_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          lhs_d          = cmd_lhs;
          rhs_d          = cmd_rhs;
          lhs_vld_d      = 1'b1;
          rhs_vld_d      = 1'b1;
          rsp_div_zero_d = (cmd_rhs == '0);
        end
        // A result seen while idle belongs to an aborted command
        if (res_fire && (stale_q != {CW{1'b1}})) stale_d = stale_q + CW'(1);
      end
      SEND: begin
        lhs_vld_d = lhs_pend;
        rhs_vld_d = rhs_pend;
        timer_d   = '0;
      end
      WAIT_RES: begin
        timer_d = timer_q + TW'(1);
        // A result on the expiry cycle takes priority over the timeout
        if (res_fire) begin
          rsp_result_d  = divider__result;
          rsp_timeout_d = 1'b0;
        end else if (timer_exp) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registered outputs and datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_rdy_q      <= 1'b0;
      lhs_q          <= '0;
      lhs_vld_q      <= 1'b0;
      rhs_q          <= '0;
      rhs_vld_q      <= 1'b0;
      res_rdy_q      <= 1'b0;
      rsp_result_q   <= '0;
      rsp_timeout_q  <= 1'b0;
      rsp_div_zero_q <= 1'b0;
      rsp_vld_q      <= 1'b0;
      stale_q        <= '0;
      timer_q        <= '0;
    end else begin
      cmd_rdy_q      <= cmd_rdy_d;
      lhs_q          <= lhs_d;
      lhs_vld_q      <= lhs_vld_d;
      rhs_q          <= rhs_d;
      rhs_vld_q      <= rhs_vld_d;
      res_rdy_q      <= res_rdy_d;
      rsp_result_q   <= rsp_result_d;
      rsp_timeout_q  <= rsp_timeout_d;
      rsp_div_zero_q <= rsp_div_zero_d;
      rsp_vld_q      <= rsp_vld_d;
      stale_q        <= stale_d;
      timer_q        <= timer_d;
    end
  end

  assign cmd_rdy             = cmd_rdy_q;
  assign divider__lhs        = lhs_q;
  assign divider__lhs_vld    = lhs_vld_q;
  assign divider__rhs        = rhs_q;
  assign divider__rhs_vld    = rhs_vld_q;
  assign divider__result_rdy = res_rdy_q;
  assign rsp_result          = rsp_result_q;
  assign rsp_timeout         = rsp_timeout_q;
  assign rsp_div_zero        = rsp_div_zero_q;
  assign rsp_vld             = rsp_vld_q;
  assign stale_cnt           = stale_q;

endmodule

// File: tb/tb_divider_requester.sv
// Directed testbench for divider_requester: the bench plays sequencer, divider
// and response consumer, checking outputs 1 time unit after each rising edge.
module tb_divider_requester;

  localparam int unsigned W  = 4;
  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] cmd_lhs, cmd_rhs;
  logic         cmd_vld, cmd_rdy;
  logic [W-1:0] d_lhs, d_rhs, d_result;
  logic         d_lhs_vld, d_lhs_rdy, d_rhs_vld, d_rhs_rdy;
  logic         d_result_vld, d_result_rdy;
  logic [W-1:0] rsp_result;
  logic         rsp_timeout, rsp_div_zero, rsp_vld, rsp_rdy;
  logic [7:0]   stale_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  divider_requester #(.W(W), .TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst                 (rst_n),
    .cmd_lhs             (cmd_lhs),
    .cmd_rhs             (cmd_rhs),
    .cmd_vld             (cmd_vld),
    .cmd_rdy             (cmd_rdy),
    .divider__lhs        (d_lhs),
    .divider__lhs_vld    (d_lhs_vld),
    .divider__lhs_rdy    (d_lhs_rdy),
    .divider__rhs        (d_rhs),
    .divider__rhs_vld    (d_rhs_vld),
    .divider__rhs_rdy    (d_rhs_rdy),
    .divider__result     (d_result),
    .divider__result_vld (d_result_vld),
    .divider__result_rdy (d_result_rdy),
    .rsp_result          (rsp_result),
    .rsp_timeout         (rsp_timeout),
    .rsp_div_zero        (rsp_div_zero),
    .rsp_vld             (rsp_vld),
    .rsp_rdy             (rsp_rdy),
    .stale_cnt           (stale_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle handshake flags and all valids low
  task automatic chk_idle(input string tag);
    chk({tag, "_cmd_rdy"}, 8'(cmd_rdy), 8'h1);
    chk({tag, "_res_rdy"}, 8'(d_result_rdy), 8'h1);
    chk({tag, "_rsp_vld"}, 8'(rsp_vld), 8'h0);
    chk({tag, "_lhs_vld"}, 8'(d_lhs_vld), 8'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    cmd_lhs = '0; cmd_rhs = '0; cmd_vld = 1'b0;
    d_lhs_rdy = 1'b0; d_rhs_rdy = 1'b0;
    d_result = '0; d_result_vld = 1'b0;
    rsp_rdy = 1'b0;

    // Reset state
    #3;
    chk("rst_cmd_rdy", 8'(cmd_rdy), 8'h0);
    chk("rst_lhs_vld", 8'(d_lhs_vld), 8'h0);
    chk("rst_rhs_vld", 8'(d_rhs_vld), 8'h0);
    chk("rst_rsp_vld", 8'(rsp_vld), 8'h0);
    chk("rst_res_rdy", 8'(d_result_rdy), 8'h0);
    chk("rst_lhs", 8'(d_lhs), 8'h0);
    chk("rst_stale", stale_cnt, 8'h0);
    #9 rst_n = 1'b1;
    chk("rel_cmd_rdy", 8'(cmd_rdy), 8'h0);
    tick();
    chk_idle("idle0");

    // 8 / 2, all ready, quotient returned on third WAIT_RES cycle
    cmd_lhs = 4'd8; cmd_rhs = 4'd2; cmd_vld = 1'b1;
    d_lhs_rdy = 1'b1; d_rhs_rdy = 1'b1; rsp_rdy = 1'b1;
    tick();
    cmd_vld = 1'b0;
    chk("t1_lhs_vld", 8'(d_lhs_vld), 8'h1);
    chk("t1_rhs_vld", 8'(d_rhs_vld), 8'h1);
    chk("t1_lhs", 8'(d_lhs), 8'h8);
    chk("t1_rhs", 8'(d_rhs), 8'h2);
    chk("t1_cmd_rdy", 8'(cmd_rdy), 8'h0);
    chk("t1_send_res_rdy", 8'(d_result_rdy), 8'h0);
    tick();
    chk("t1_lhs_done", 8'(d_lhs_vld), 8'h0);
    chk("t1_rhs_done", 8'(d_rhs_vld), 8'h0);
    chk("t1_wait_res_rdy", 8'(d_result_rdy), 8'h1);
    tick();
    tick();
    d_result = 4'd4; d_result_vld = 1'b1;
    tick();
    d_result_vld = 1'b0;
    chk("t1_rsp_vld", 8'(rsp_vld), 8'h1);
    chk("t1_rsp_result", 8'(rsp_result), 8'h4);
    chk("t1_rsp_timeout", 8'(rsp_timeout), 8'h0);
    chk("t1_rsp_div_zero", 8'(rsp_div_zero), 8'h0);
    chk("t1_resp_res_rdy", 8'(d_result_rdy), 8'h0);
    tick();
    chk_idle("t1_end");

    // Split acceptance: lhs accepted at once, rhs held off for 5 cycles
    cmd_lhs = 4'd6; cmd_rhs = 4'd3; cmd_vld = 1'b1;
    d_lhs_rdy = 1'b1; d_rhs_rdy = 1'b0;
    tick();
    cmd_vld = 1'b0;
    chk("t2_c1_lhs_vld", 8'(d_lhs_vld), 8'h1);
    chk("t2_c1_rhs_vld", 8'(d_rhs_vld), 8'h1);
    for (int i = 2; i <= 6; i++) begin
      tick();
      chk("t2_lhs_dropped", 8'(d_lhs_vld), 8'h0);
      chk("t2_rhs_held", 8'(d_rhs_vld), 8'h1);
      chk("t2_rhs_data", 8'(d_rhs), 8'h3);
      chk("t2_send_res_rdy", 8'(d_result_rdy), 8'h0);
      if (i == 6) d_rhs_rdy = 1'b1;
    end
    tick();
    chk("t2_rhs_done", 8'(d_rhs_vld), 8'h0);
    chk("t2_wait_res_rdy", 8'(d_result_rdy), 8'h1);
    d_result = 4'd2; d_result_vld = 1'b1;
    tick();
    d_result_vld = 1'b0;
    chk("t2_rsp_vld", 8'(rsp_vld), 8'h1);
    chk("t2_rsp_result", 8'(rsp_result), 8'h2);
    tick();
    chk_idle("t2_end");

    // Divide by zero followed by 10 cycles of response backpressure
    cmd_lhs = 4'd5; cmd_rhs = 4'd0; cmd_vld = 1'b1; rsp_rdy = 1'b0;
    tick();
    cmd_vld = 1'b0;
    tick();
    d_result = 4'hF; d_result_vld = 1'b1;
    tick();
    d_result_vld = 1'b0;
    cmd_lhs = 4'd9; cmd_rhs = 4'd3; cmd_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t3_bp_rsp_vld", 8'(rsp_vld), 8'h1);
      chk("t3_bp_result", 8'(rsp_result), 8'hF);
      chk("t3_bp_div_zero", 8'(rsp_div_zero), 8'h1);
      chk("t3_bp_timeout", 8'(rsp_timeout), 8'h0);
      chk("t3_bp_cmd_rdy", 8'(cmd_rdy), 8'h0);
      chk("t3_bp_res_rdy", 8'(d_result_rdy), 8'h0);
      tick();
    end
    chk("t3_bp_still_vld", 8'(rsp_vld), 8'h1);
    rsp_rdy = 1'b1;
    tick();
    chk_idle("t3_after_hs");
    tick();
    cmd_vld = 1'b0;
    chk("t3_new_lhs_vld", 8'(d_lhs_vld), 8'h1);
    chk("t3_new_lhs", 8'(d_lhs), 8'h9);
    chk("t3_new_div_zero", 8'(rsp_div_zero), 8'h0);
    tick();
    d_result = 4'd3; d_result_vld = 1'b1;
    tick();
    d_result_vld = 1'b0;
    chk("t3_new_result", 8'(rsp_result), 8'h3);
    tick();
    chk_idle("t3_end");

    // Timeout, then a late result counted as stale
    cmd_lhs = 4'd7; cmd_rhs = 4'd2; cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
    tick();
    chk("t4_wait_entry", 8'(d_result_rdy), 8'h1);
    for (int i = 1; i < int'(TO); i++) begin
      tick();
      chk("t4_no_rsp_yet", 8'(rsp_vld), 8'h0);
    end
    tick();
    chk("t4_rsp_vld", 8'(rsp_vld), 8'h1);
    chk("t4_rsp_timeout", 8'(rsp_timeout), 8'h1);
    chk("t4_rsp_result", 8'(rsp_result), 8'h0);
    tick();
    chk_idle("t4_idle");
    chk("t4_stale0", stale_cnt, 8'h0);
    d_result = 4'd3; d_result_vld = 1'b1;
    tick();
    d_result_vld = 1'b0;
    chk("t4_stale1", stale_cnt, 8'h1);
    tick();
    chk("t4_stale_hold", stale_cnt, 8'h1);

    // Async reset while waiting for a result
    cmd_lhs = 4'd9; cmd_rhs = 4'd3; cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
    tick();
    chk("t5_in_wait", 8'(d_result_rdy), 8'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_rst_cmd_rdy", 8'(cmd_rdy), 8'h0);
    chk("t5_rst_lhs_vld", 8'(d_lhs_vld), 8'h0);
    chk("t5_rst_rhs_vld", 8'(d_rhs_vld), 8'h0);
    chk("t5_rst_rsp_vld", 8'(rsp_vld), 8'h0);
    chk("t5_rst_res_rdy", 8'(d_result_rdy), 8'h0);
    chk("t5_rst_stale", stale_cnt, 8'h0);
    #2 rst_n = 1'b1;
    tick();
    chk_idle("t5_idle");
    cmd_vld = 1'b1;
    tick();
    cmd_vld = 1'b0;
    chk("t5_lhs", 8'(d_lhs), 8'h9);
    chk("t5_rhs", 8'(d_rhs), 8'h3);
    tick();
    d_result = 4'd3; d_result_vld = 1'b1;
    tick();
    d_result_vld = 1'b0;
    chk("t5_rsp_vld", 8'(rsp_vld), 8'h1);
    chk("t5_rsp_result", 8'(rsp_result), 8'h3);
    chk("t5_rsp_timeout", 8'(rsp_timeout), 8'h0);
    tick();
    chk_idle("t5_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
